// File: rtl/bit_stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_serializer
//  Description : Parallel-in, serial-out stage feeding the serial sequence
//                detector. Accepts WIDTH-bit words over a valid/ready
//                handshake and emits one bit per clock on serial_out.
//                Optional macro SERIALIZER_PREFETCH_EN adds a one-word hold
//                register so that back-to-back words are sent without a gap.
//  Ports       : clock        - system clock, rising edge
//                reset        - asynchronous, active-high reset
//                data_in      - parallel word to serialize
//                data_valid   - data_in is valid
//                data_ready   - serializer can accept a word this cycle
//                serial_out   - serial bit stream (to detector sequence_in)
//                serial_valid - serial_out carries a payload bit
//                busy         - shift in progress
//                word_done    - pulse while last bit of a word is on serial_out
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_stream_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int              c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    // Low during reset and until the first edge after release, so that
    // data_ready stays decoded from registers only.
    logic               ready_en_q;

    logic               w_accept;
    logic               w_last_bit;
    logic [WIDTH-1:0]   w_shifted;

`ifdef SERIALIZER_PREFETCH_EN
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
`endif

    assign w_accept   = data_valid && data_ready;
    assign w_last_bit = (state_q == S_SHIFT) && (cnt_q == '0);
    // Zero fill keeps the register clean once a word has drained.
    assign w_shifted  = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
        end
    end

`ifdef SERIALIZER_PREFETCH_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef SERIALIZER_PREFETCH_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    shift_d = data_in;
                    cnt_d   = c_CNT_LAST;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d = w_shifted;
                cnt_d   = cnt_q - c_CNT_W'(1);
                if (w_last_bit) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
`ifdef SERIALIZER_PREFETCH_EN
                    // A held word takes priority; data_ready is low while
                    // the hold register is full, so both cannot happen.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        cnt_d       = c_CNT_LAST;
                        state_d     = S_SHIFT;
                        hold_full_d = 1'b0;
                    end else if (w_accept) begin
                        shift_d = data_in;
                        cnt_d   = c_CNT_LAST;
                        state_d = S_SHIFT;
                    end
`endif
                end
`ifdef SERIALIZER_PREFETCH_EN
                else if (w_accept) begin
                    hold_d      = data_in;
                    hold_full_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registers only
    // ------------------------------------------------------------------
    always_comb begin
        busy         = (state_q == S_SHIFT);
        serial_valid = (state_q == S_SHIFT);
        serial_out   = (state_q == S_SHIFT) &&
                       (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
        word_done    = w_last_bit;
`ifdef SERIALIZER_PREFETCH_EN
        data_ready   = ready_en_q && !hold_full_q;
`else
        data_ready   = ready_en_q && (state_q == S_IDLE);
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_stream_serializer
//  Description : Self-checking bench for bit_stream_serializer. Three
//                instances (WIDTH/MSB_FIRST = 8/1, 8/0, 1/1) share the same
//                stimulus; a word-level reference model predicts every output
//                each cycle. Honours SERIALIZER_PREFETCH_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_stream_serializer;

`ifdef SERIALIZER_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic [2:0] rdy, so, sv, bsy, wd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy[0]), .serial_out(so[0]), .serial_valid(sv[0]),
        .busy(bsy[0]), .word_done(wd[0]));

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(rdy[1]), .serial_out(so[1]), .serial_valid(sv[1]),
        .busy(bsy[1]), .word_done(wd[1]));

    bit_stream_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) dut2 (
        .clock(clock), .reset(reset), .data_in(data_in[0:0]), .data_valid(data_valid),
        .data_ready(rdy[2]), .serial_out(so[2]), .serial_valid(sv[2]),
        .busy(bsy[2]), .word_done(wd[2]));

    // ---------------- reference model (word level) ----------------
    int         m_w   [3] = '{8, 8, 1};
    bit         m_msb [3] = '{1'b1, 1'b0, 1'b1};
    int         m_rem [3];   // payload bits still to be sent of current word
    logic [7:0] m_cur [3];
    logic [7:0] m_hold[3];
    bit         m_hv  [3];
    bit         m_en  [3];
    bit         acc   [3];   // model's view of "word accepted at last edge"

    function automatic logic [4:0] exp_vec(int k);
        logic r, b, v, d;
        int   idx;
        r   = m_en[k] && (PREFETCH ? !m_hv[k] : (m_rem[k] == 0));
        v   = (m_rem[k] > 0);
        idx = m_w[k] - m_rem[k];              // bits already sent
        b   = v ? (m_msb[k] ? m_cur[k][m_w[k]-1-idx] : m_cur[k][idx]) : 1'b0;
        d   = (m_rem[k] == 1);
        return {r, b, v, v, d};
    endfunction

    task automatic model_reset(int k);
        m_en[k] = 1'b0; m_rem[k] = 0; m_hv[k] = 1'b0; acc[k] = 1'b0;
    endtask

    task automatic model_step(int k, logic dv, logic [7:0] d);
        logic [4:0] e;
        logic [7:0] din;
        e      = exp_vec(k);
        din    = (m_w[k] == 8) ? d : {7'd0, d[0]};
        acc[k] = dv && e[4];
        if (m_rem[k] > 0) begin
            m_rem[k]--;
            if (m_rem[k] == 0) begin
                if (PREFETCH && m_hv[k]) begin
                    m_cur[k] = m_hold[k]; m_rem[k] = m_w[k]; m_hv[k] = 1'b0;
                end else if (acc[k]) begin
                    m_cur[k] = din; m_rem[k] = m_w[k];
                end
            end else if (acc[k]) begin
                m_hold[k] = din; m_hv[k] = 1'b1;
            end
        end else if (acc[k]) begin
            m_cur[k] = din; m_rem[k] = m_w[k];
        end
        m_en[k] = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    bit          cap = 1'b0;
    int          ncap, nsv, nwd;
    logic [31:0] str0, str1;

    task automatic start_cap();
        cap = 1'b1; ncap = 0; nsv = 0; nwd = 0; str0 = '0; str1 = '0;
    endtask

    // One clock: drive, check at negedge, advance model at posedge.
    task automatic cycle(input logic dv, input logic [7:0] d);
        data_valid = dv;
        data_in    = d;
        @(negedge clock);
        for (int k = 0; k < 3; k++)
            chk($sformatf("dut%0d_outputs{rdy,out,valid,busy,done}", k),
                {27'd0, rdy[k], so[k], sv[k], bsy[k], wd[k]}, {27'd0, exp_vec(k)});
        if (cap) begin
            str0 = {str0[30:0], so[0]};
            str1 = {str1[30:0], so[1]};
            nsv += int'(sv[0]);
            nwd += int'(wd[0]);
            ncap++;
        end
        @(posedge clock);
        for (int k = 0; k < 3; k++) begin
            if (reset) model_reset(k);
            else       model_step(k, dv, d);
        end
        #1;
    endtask

    // Hold data_valid with d until instance 0 takes it (bounded).
    task automatic send_word(input logic [7:0] d);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle(1'b1, d);
            got = acc[0];
        end
        chk("accept_timeout", {31'd0, got}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            model_reset(k);
            m_cur[k] = '0;
            m_hold[k] = '0;
        end

        // Reset held, then released with 5 idle cycles.
        repeat (3) cycle(1'b0, 8'h00);
        reset = 1'b0;
        repeat (5) cycle(1'b0, 8'h00);
        chk("idle_ready", {29'd0, rdy}, 32'h7);
        chk("idle_valid_busy_done", {23'd0, sv, bsy, wd}, 32'h0);

        // 8'hB0 then 8'hB4 with data_valid held.
        send_word(8'hB0);
        start_cap();
        send_word(8'hB4);
        while (ncap < 17) cycle(1'b0, 8'h00);
        cap = 1'b0;
        chk("b0_b4_stream", {15'd0, str0[16:0]},
            PREFETCH ? {15'd0, 17'b10110000_10110100_0}
                     : {15'd0, 17'b10110000_0_10110100});
        repeat (10) cycle(1'b0, 8'h00);

        // 8'h0D on both bit orders.
        send_word(8'h0D);
        start_cap();
        repeat (8) cycle(1'b0, 8'h00);
        cap = 1'b0;
        chk("lsb_first_0d", {24'd0, str1[7:0]}, 32'b10110000);
        chk("msb_first_0d", {24'd0, str0[7:0]}, 32'h0D);
        repeat (4) cycle(1'b0, 8'h00);

        // Reset on the 3rd bit of 8'hFF, then a clean 8'h0F.
        send_word(8'hFF);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        chk("ff_bit3_before_reset", {31'd0, so[0]}, 32'd1);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) model_reset(k);
        chk("reset_async_clears", {27'd0, rdy[0], so[0], sv[0], bsy[0], wd[0]}, 32'd0);
        repeat (2) cycle(1'b0, 8'h00);
        reset = 1'b0;
        repeat (3) cycle(1'b0, 8'h00);
        send_word(8'h0F);
        start_cap();
        repeat (8) cycle(1'b0, 8'h00);
        cap = 1'b0;
        chk("after_reset_0f", {24'd0, str0[7:0]}, 32'h0F);
        chk("after_reset_0f_done", nwd, 32'd1);
        repeat (4) cycle(1'b0, 8'h00);

        // Three 8'hBB words back-to-back.
        send_word(8'hBB);
        start_cap();
        send_word(8'hBB);
        send_word(8'hBB);
        while (ncap < 24) cycle(1'b0, 8'h00);
        cap = 1'b0;
        chk("bb_x3_valid_cycles", nsv, PREFETCH ? 32'd24 : 32'd22);
        chk("bb_x3_word_done",    nwd, PREFETCH ? 32'd3  : 32'd2);
        repeat (12) cycle(1'b0, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 8'($urandom));
        repeat (12) cycle(1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
Parallel-in, serial-out stage that sits directly upstream of the serial sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on serial_out, which drives the detector's sequence_in. serial_valid, busy and word_done give framing to the surrounding test and control logic.

Parameters:
WIDTH, 8, word width in bits; legal values are 1 to 32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  WIDTH  parallel word to serialize
data_valid  input  1  data_in is valid
data_ready  output  1  serializer can accept a word this cycle
serial_out  output  1  serial bit stream (to detector sequence_in)
serial_valid  output  1  serial_out carries a payload bit
busy  output  1  shift in progress
word_done  output  1  one-cycle pulse while the last bit of a word is on serial_out

Behaviour:
- Reset is asynchronous, active-high; clock is clock. On reset:
  - State goes to IDLE; shift register and bit counter are cleared; hold register is empty.
  - serial_out=0, serial_valid=0, busy=0, word_done=0, data_ready=0 while reset is asserted.
  - data_ready=1 from the first cycle after reset is released.
- All outputs are decoded from registers only. There is no combinational path from data_in or data_valid to any output.
- A word is accepted on a rising edge where data_valid && data_ready. data_in is ignored at all other times.
- States:
  - IDLE: busy=0, serial_valid=0, serial_out=0, data_ready=1. On accept: shift_reg<=data_in, cnt<=WIDTH-1, go to SHIFT.
  - SHIFT: busy=1, serial_valid=1. serial_out = shift_reg[WIDTH-1] if MSB_FIRST, else shift_reg[0]. Each edge shifts by one (left if MSB_FIRST, right otherwise, zero fill) and sets cnt<=cnt-1. data_ready=0 (base build).
  - When cnt==0: word_done=1 that cycle; next state is IDLE.
- Latency: the first bit appears on serial_out in the cycle immediately after the accepting edge. A word occupies exactly WIDTH cycles.
- In the base build there is exactly one IDLE cycle (serial_out=0, serial_valid=0) between back-to-back words.
- cnt width is max(1, $clog2(WIDTH)). With WIDTH=1, every word lasts one cycle and word_done is high in that cycle.
- data_valid held high while not ready: the word is not consumed and is accepted on the first ready edge. Values are not latched early.
- Reset asserted mid-word: the word is discarded immediately and output goes to 0 with no partial completion. word_done does not fire.

Optional Feature:
Macro SERIALIZER_PREFETCH_EN.
- Defined:
  - Adds a one-word hold register, and data_ready = !hold_full.
  - In IDLE, an accepted word goes straight to the shifter.
  - In SHIFT, an accepted word goes to the hold register.
  - At the edge ending the last bit (cnt==0), if hold_full, the hold word loads into the shifter, cnt<=WIDTH-1, the state stays SHIFT and hold_full clears. Words are therefore gapless and serial_valid stays high.
  - An accept on that same edge is allowed only when the hold register is empty; that word then loads directly into the shifter.
  - Reset clears hold_full.
- Undefined: the behaviour is exactly the base build above.

Test Plan:
- Reset, then idle 5 cycles -> serial_out=0, serial_valid=0, busy=0, word_done=0; data_ready=1 after release.
- WIDTH=8, MSB_FIRST=1, accept 8'hB0 -> serial_out 1,0,1,1,0,0,0,0 on the 8 following cycles; serial_valid=1 for those 8 cycles; word_done only on the 8th; then IDLE.
- data_valid held with 8'hB0 then 8'hB4 continuously -> second word accepted on the IDLE cycle, one-cycle gap with serial_valid=0; bitstream 10110000 0 10110100 (gap bit shown as 0).
- MSB_FIRST=0, accept 8'h0D -> serial_out 1,0,1,1,0,0,0,0.
- Reset asserted on the 3rd bit of 8'hFF -> serial_out=0 and busy=0 immediately; no word_done; the next accepted word 8'h0F starts cleanly with 0,0,0,0,1,1,1,1.
- With SERIALIZER_PREFETCH_EN, send 8'hBB, 8'hBB, 8'hBB back-to-back -> 24 consecutive serial_valid cycles with no gap; data_ready low only while the hold register is full; word_done on cycles 8, 16 and 24.
